// File: rtl/vector_mem_ctrl.sv
// Strided vector load/store sequencer driving NUM_ELEM parallel memory banks.
// Optional macro VMEM_CTRL_PERF_EN adds a saturating perf_beats issued-beat counter.
module vector_mem_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned NUM_ELEM   = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_is_store,
    input  logic [ADDR_WIDTH-1:0]            cmd_base,
    input  logic [ADDR_WIDTH-1:0]            cmd_stride,
    input  logic [15:0]                      cmd_count,
    input  logic [NUM_ELEM-1:0]              cmd_mask,
    input  logic                             st_valid,
    output logic                             st_ready,
    input  logic [DATA_WIDTH*NUM_ELEM-1:0]   st_data,
    output logic                             ld_valid,
    output logic [DATA_WIDTH*NUM_ELEM-1:0]   ld_data,
    output logic                             done,
    output logic [NUM_ELEM-1:0]              mem_read_req,
    output logic [ADDR_WIDTH*NUM_ELEM-1:0]   mem_read_addr,
    input  logic [DATA_WIDTH*NUM_ELEM-1:0]   mem_read_data,
    output logic [NUM_ELEM-1:0]              mem_write_req,
    output logic [ADDR_WIDTH*NUM_ELEM-1:0]   mem_write_addr,
    output logic [DATA_WIDTH*NUM_ELEM-1:0]   mem_write_data
`ifdef VMEM_CTRL_PERF_EN
    ,
    output logic [31:0]                      perf_beats
`endif
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    accept;
    logic                    beat;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   stride_q;
    logic [NUM_ELEM-1:0]     mask_q;
    logic [CNT_W-1:0]        beats_left_q;
    logic                    ld_valid_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and beat issue decisions
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        beat    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_count == CNT_W'(0)) begin
                        state_d = DRAIN;
                    end else if (cmd_is_store) begin
                        state_d = STORE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                beat = 1'b1;
                if (beats_left_q == CNT_W'(1)) begin
                    state_d = DRAIN;
                end
            end
            STORE: begin
                if (st_valid) begin
                    beat = 1'b1;
                    if (beats_left_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command latch, address accumulator and beat counter
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            stride_q     <= '0;
            mask_q       <= '0;
            beats_left_q <= '0;
            ld_valid_q   <= 1'b0;
        end else begin
            ld_valid_q <= (state_q == LOAD);
            if (accept) begin
                addr_q       <= cmd_base;
                stride_q     <= cmd_stride;
                mask_q       <= cmd_mask;
                beats_left_q <= cmd_count;
            end else if (beat) begin
                addr_q       <= addr_q + stride_q;
                beats_left_q <= beats_left_q - CNT_W'(1);
            end
        end
    end

    // Handshake, memory request and load return outputs
    always_comb begin
        cmd_ready      = (state_q == IDLE);
        st_ready       = (state_q == STORE);
        done           = (state_q == DRAIN);
        ld_valid       = ld_valid_q;
        mem_read_req   = '0;
        mem_read_addr  = '0;
        mem_write_req  = '0;
        mem_write_addr = '0;
        mem_write_data = '0;
        ld_data        = '0;
        if (state_q == LOAD) begin
            mem_read_req  = mask_q;
            mem_read_addr = {NUM_ELEM{addr_q}};
        end
        if ((state_q == STORE) && st_valid) begin
            mem_write_req  = mask_q;
            mem_write_addr = {NUM_ELEM{addr_q}};
            mem_write_data = st_data;
        end
        // Mask stays latched until the next acceptance, which follows the last return
        for (int unsigned i = 0; i < NUM_ELEM; i++) begin
            if (ld_valid_q && mask_q[i]) begin
                ld_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_read_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef VMEM_CTRL_PERF_EN
    logic [31:0] perf_q;

    // Saturating count of issued beats
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (beat && (perf_q != '1)) begin
            perf_q <= perf_q + 32'(1);
        end
    end

    assign perf_beats = perf_q;
`endif

endmodule

// File: doc/vector_mem_ctrl.md
VECTOR_MEM_CTRL -- requirements
Module: vector_mem_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16, bits per lane element.
REQ-002 Parameter ADDR_WIDTH, default 16, per-bank word address width.
REQ-003 Parameter NUM_ELEM, default 64, lane/bank count.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted this cycle when high with cmd_valid.
REQ-008 cmd_is_store  in  1  1=store, 0=load.
REQ-009 cmd_base  in  ADDR_WIDTH  first beat address.
REQ-010 cmd_stride  in  ADDR_WIDTH  address increment per beat.
REQ-011 cmd_count  in  16  beats to transfer.
REQ-012 cmd_mask  in  NUM_ELEM  lane enable.
REQ-013 st_valid  in  1; st_ready  out  1; st_data  in  DATA_WIDTH*NUM_ELEM  store beat handshake and data.
REQ-014 ld_valid  out  1; ld_data  out  DATA_WIDTH*NUM_ELEM  load beat result.
REQ-015 done  out  1  one-cycle pulse at command completion.
REQ-016 mem_read_req  out  NUM_ELEM; mem_read_addr  out  ADDR_WIDTH*NUM_ELEM; mem_read_data  in  DATA_WIDTH*NUM_ELEM.
REQ-017 mem_write_req  out  NUM_ELEM; mem_write_addr  out  ADDR_WIDTH*NUM_ELEM; mem_write_data  out  DATA_WIDTH*NUM_ELEM.

Function
REQ-018 FSM states IDLE, LOAD, STORE, DRAIN; cmd_ready SHALL be high only in IDLE.
REQ-019 Acceptance latches base, stride, count, mask, and enters LOAD or STORE; count 0 goes to DRAIN with no memory requests.
REQ-020 Beat k address SHALL be base + k*stride modulo 2^ADDR_WIDTH, produced by an accumulator, identical across all lanes.
REQ-021 LOAD: one beat issued every cycle; mem_read_req = latched mask; after the last beat, go to DRAIN.
REQ-022 Memory returns data one cycle after mem_read_req; ld_valid SHALL be mem_read_req-issue delayed one cycle, with ld_data = mem_read_data with masked lanes forced to zero.
REQ-023 STORE: st_ready high in STORE; a beat is written only in cycles with st_valid&&st_ready, mem_write_req = mask, mem_write_data = st_data; no write otherwise.
REQ-024 After the last store beat go to DRAIN; DRAIN lasts one cycle, asserts done, returns to IDLE.
REQ-025 Load of N beats accepted cycle T: reads T+1..T+N, ld_valid T+2..T+N+1, done at T+N+1 coincident with last ld_valid.
REQ-026 Store of N beats: done in the cycle after the Nth accepted st beat.
REQ-027 Memory request outputs SHALL be zero whenever no beat is issued; addresses don't-care then but driven zero.

Reset
REQ-028 On reset: state IDLE, cmd_ready 1, st_ready/ld_valid/done/mem_*_req 0, all addresses/data outputs 0, accumulator and counters 0.
REQ-029 Reset mid-command aborts it; in-flight load data SHALL not produce ld_valid; no done pulse.

Configuration
REQ-030 Macro VMEM_CTRL_PERF_EN: when defined, add output perf_beats (32 bits) counting issued beats since reset, saturating at all-ones; when undefined, port and counter absent and behaviour otherwise identical.

Verification
REQ-031 Load base 0x0010, stride 2, count 4, mask all-ones -> addresses 0x10,0x12,0x14,0x16 on consecutive cycles; ld_valid 4 cycles lagging by one; done with 4th.
REQ-032 Store count 3 with st_valid toggled 1,0,1,0,1 -> exactly 3 writes on st_valid-high cycles; done the following cycle.
REQ-033 Load base 0xFFFE, stride 3, count 3 -> addresses 0xFFFE, 0x0001, 0x0004 (wrap).
REQ-034 Count 0 -> no mem requests; done exactly one cycle after acceptance; cmd_ready returns next cycle.
REQ-035 Mask 0x...05 load -> only lanes 0 and 2 request; other ld_data lanes zero.
REQ-036 Reset asserted during 8-beat load at beat 3 -> all outputs at reset values next cycle, no further ld_valid, no done.
